pcc_attr_ctrl: RTL and testbench

Attribute-memory controller for the PC Card host interface. It synchronizes the card-side strobes into the CLK domain and sequences every attribute-space access. It serves Card Information Structure (CIS) bytes from an external ROM port and owns the Configuration Option Register (COR) and the Card Configuration and Status Register (CCSR). From those registers it derives the function soft reset, the CONFIGURED state, power-down, and IREQ# generation in level or pulse mode.

---
 rtl/pcc_attr_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_pcc_attr_ctrl.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/pcc_attr_ctrl.sv
// PC Card attribute-memory controller: synchronizes the card strobes into the
// CLK domain, serves CIS bytes from an external ROM, and owns the COR and
// CCSR. Soft reset, CONFIGURED, power-down and IREQ# are derived from them.
module pcc_attr_ctrl #(
  parameter int SRST_CYCLES = 16,
  parameter int IRQ_PULSE   = 8
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       CE_N,
  input  logic       REGSEL_N,
  input  logic       OE_N,
  input  logic       WE_N,
  input  logic [9:0] A,
  input  logic [7:0] D_in,
  output logic [7:0] D_out,
  output logic       DDIR,
  output logic [7:0] CIS_ADDR,
  input  logic [7:0] CIS_DATA,
  input  logic       INT_IN,
  output logic       CONFIGURED,
  output logic       SOFT_RESET,
  output logic       PWRDWN,
  output logic       IREQ_N,
  output logic       READY
);

  localparam int SW = $clog2(SRST_CYCLES + 1);
  localparam int PW = $clog2(IRQ_PULSE + 1);

  typedef enum logic [2:0] {IDLE, RD_WAIT, RD_HOLD, WR_HOLD, COMMIT} state_t;

  state_t state, state_nx;

  logic       ce_n_p0, ce_n_p1, regsel_n_p0, regsel_n_p1;
  logic       oe_n_p0, oe_n_p1, we_n_p0, we_n_p1, int_p0, int_p1;
  logic [9:1] a_p0, a_p1;
  logic [7:0] d_p0, d_p1;

  logic       sel, rd, wr, armed;
  logic [7:0] idx, reg_rd;
  logic       ld_reg, ld_cis, ld_rom, cap_addr, cap_data, do_commit;
  logic       wr_reg;
  logic [7:0] wr_idx, wr_data;
  logic       cor_wr, ccsr_wr;

  logic [6:0]    cor;
  logic          pwrdwn;
  logic          srst_req;
  logic [SW-1:0] srst_cnt;
  logic [PW-1:0] pulse_cnt;
  logic          int_prev;

  logic unused_a0;
  assign unused_a0 = A[0];

  // Stage boundary: two-flop synchronizers; address and data travel with the strobes
  always_ff @(posedge CLK) begin
    ce_n_p0     <= CE_N;      ce_n_p1     <= ce_n_p0;
    regsel_n_p0 <= REGSEL_N;  regsel_n_p1 <= regsel_n_p0;
    oe_n_p0     <= OE_N;      oe_n_p1     <= oe_n_p0;
    we_n_p0     <= WE_N;      we_n_p1     <= we_n_p0;
    int_p0      <= INT_IN;    int_p1      <= int_p0;
    a_p0        <= A[9:1];    a_p1        <= a_p0;
    d_p0        <= D_in;      d_p1        <= d_p0;
  end

  assign DDIR = !CE_N && !REGSEL_N && !OE_N;
  assign sel  = !ce_n_p1 && !regsel_n_p1;
  assign rd   = sel && !oe_n_p1;
  assign wr   = sel && !we_n_p1;
  assign idx  = a_p1[8:1];

  assign CONFIGURED = (cor[5:0] == 6'd1) && !SOFT_RESET;
  assign PWRDWN     = pwrdwn;

  // Register read mux; undecoded indices read as zero
  always_comb begin
    reg_rd = 8'h00;
    if (idx == 8'd0)      reg_rd = {SOFT_RESET, cor};
    else if (idx == 8'd1) reg_rd = {5'b0, pwrdwn, int_p1, 1'b0};
  end

  // A strobe still low when RESET released must go inactive before it counts again
  always_ff @(posedge CLK) begin
    if (RESET) armed <= 1'b0;
    else       armed <= armed || !(rd || wr);
  end

  // Access sequencer state register
  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= state_nx;
  end

  // Access sequencer next state and datapath strobes; write wins over read
  always_comb begin
    state_nx  = state;
    ld_reg    = 1'b0;
    ld_cis    = 1'b0;
    ld_rom    = 1'b0;
    cap_addr  = 1'b0;
    cap_data  = 1'b0;
    do_commit = 1'b0;
    case (state)
      IDLE: begin
        if (armed && wr) begin
          cap_addr = 1'b1;
          cap_data = 1'b1;
          state_nx = WR_HOLD;
        end else if (armed && rd) begin
          if (a_p1[9]) begin
            ld_reg   = 1'b1;
            state_nx = RD_HOLD;
          end else begin
            ld_cis   = 1'b1;
            state_nx = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        ld_rom   = 1'b1;
        state_nx = RD_HOLD;
      end
      RD_HOLD: begin
        if (oe_n_p1 || !sel) state_nx = IDLE;
      end
      WR_HOLD: begin
        if (we_n_p1 || ce_n_p1) state_nx = COMMIT;
        else                    cap_data = 1'b1;
      end
      COMMIT: begin
        do_commit = 1'b1;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Read data and CIS address registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      D_out    <= 8'h00;
      CIS_ADDR <= 8'h00;
    end else begin
      if (ld_reg) D_out    <= reg_rd;
      if (ld_cis) CIS_ADDR <= idx;
      if (ld_rom) D_out    <= CIS_DATA;
    end
  end

  // Write address/data capture; data keeps following D_in while WE is held low
  always_ff @(posedge CLK) begin
    if (cap_addr) begin
      wr_reg <= a_p1[9];
      wr_idx <= idx;
    end
    if (cap_data) wr_data <= d_p1;
  end

  assign cor_wr  = do_commit && wr_reg && (wr_idx == 8'd0);
  assign ccsr_wr = do_commit && wr_reg && (wr_idx == 8'd1);

  // COR and soft-reset sequencing; a set SRESET bit restarts the minimum width
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cor        <= 7'h00;
      SOFT_RESET <= 1'b0;
      srst_req   <= 1'b0;
      srst_cnt   <= '0;
    end else begin
      if (cor_wr) begin
        cor      <= wr_data[6:0];
        srst_req <= wr_data[7];
        if (wr_data[7]) cor[5:0] <= 6'd0;
      end
      if (cor_wr && wr_data[7]) begin
        SOFT_RESET <= 1'b1;
        srst_cnt   <= SW'(SRST_CYCLES);
      end else if (SOFT_RESET) begin
        if (srst_cnt > SW'(1)) begin
          srst_cnt <= srst_cnt - SW'(1);
        end else begin
          srst_cnt <= '0;
          if (cor_wr || !srst_req) SOFT_RESET <= 1'b0;
        end
      end
    end
  end

  // CCSR power-down bit; soft reset forces it clear
  always_ff @(posedge CLK) begin
    if (RESET)                                      pwrdwn <= 1'b0;
    else if (SOFT_RESET || (cor_wr && wr_data[7]))  pwrdwn <= 1'b0;
    else if (ccsr_wr)                               pwrdwn <= wr_data[2];
  end

  // IREQ# generation: level follows INT_IN, pulse mode retriggers on each rising edge
  always_ff @(posedge CLK) begin
    if (RESET) begin
      IREQ_N    <= 1'b1;
      pulse_cnt <= '0;
      int_prev  <= 1'b0;
    end else begin
      int_prev <= int_p1;
      if (!CONFIGURED) begin
        IREQ_N    <= 1'b1;
        pulse_cnt <= '0;
      end else if (cor[6]) begin
        IREQ_N    <= !int_p1;
        pulse_cnt <= '0;
      end else if (int_p1 && !int_prev) begin
        IREQ_N    <= 1'b0;
        pulse_cnt <= PW'(IRQ_PULSE);
      end else if (pulse_cnt > PW'(1)) begin
        pulse_cnt <= pulse_cnt - PW'(1);
      end else begin
        pulse_cnt <= '0;
        IREQ_N    <= 1'b1;
      end
    end
  end

  // Card ready mirrors the soft reset, one register late
  always_ff @(posedge CLK) begin
    if (RESET) READY <= 1'b0;
    else       READY <= !SOFT_RESET;
  end

endmodule

// File: tb/tb_pcc_attr_ctrl.sv
// Directed bench for pcc_attr_ctrl: register and CIS reads, writes, soft
// reset timing, IREQ level/pulse modes and RESET during a write.
module tb_pcc_attr_ctrl;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       CE_N, REGSEL_N, OE_N, WE_N;
  logic [9:0] A;
  logic [7:0] D_in, D_out, CIS_ADDR, cis_data;
  logic       DDIR, INT_IN, CONFIGURED, SOFT_RESET, PWRDWN, IREQ_N, READY;

  int errors = 0;
  int checks = 0;
  int srst_hi = 0;

  always #5 CLK = ~CLK;

  // CIS ROM model: only byte 5 holds the expected pattern
  assign cis_data = (CIS_ADDR == 8'h05) ? 8'h5A : 8'hC3;

  pcc_attr_ctrl #(.SRST_CYCLES(16), .IRQ_PULSE(8)) dut (
    .CLK(CLK), .RESET(RESET), .CE_N(CE_N), .REGSEL_N(REGSEL_N), .OE_N(OE_N),
    .WE_N(WE_N), .A(A), .D_in(D_in), .D_out(D_out), .DDIR(DDIR),
    .CIS_ADDR(CIS_ADDR), .CIS_DATA(cis_data), .INT_IN(INT_IN),
    .CONFIGURED(CONFIGURED), .SOFT_RESET(SOFT_RESET), .PWRDWN(PWRDWN),
    .IREQ_N(IREQ_N), .READY(READY)
  );

  // Counts cycles spent in soft reset
  always @(negedge CLK) if (SOFT_RESET === 1'b1) srst_hi = srst_hi + 1;

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [9:0] addr, input logic [7:0] data);
    A = addr; D_in = data; CE_N = 0; REGSEL_N = 0; WE_N = 0;
    tick(4);
    WE_N = 1; D_in = 8'hFF;
    tick(4);
    CE_N = 1; REGSEL_N = 1;
    tick(1);
  endtask

  task automatic rd(input logic [9:0] addr, input int lat, input logic [7:0] prev,
                    input logic [7:0] exp, input string tag);
    A = addr; CE_N = 0; REGSEL_N = 0; OE_N = 0;
    #1 chk({tag, "_ddir_on"}, DDIR, 1);
    tick(lat - 1);
    chk({tag, "_early"}, D_out, prev);
    tick(1);
    chk(tag, D_out, exp);
    OE_N = 1; CE_N = 1; REGSEL_N = 1;
    #1 chk({tag, "_ddir_off"}, DDIR, 0);
    tick(3);
  endtask

  initial begin
    int lows, falls;
    logic prev_irq;
    RESET = 1; CE_N = 1; REGSEL_N = 1; OE_N = 1; WE_N = 1;
    A = '0; D_in = '0; INT_IN = 0;
    tick(4);
    chk("rst_dout", D_out, 8'h00);
    chk("rst_cisaddr", CIS_ADDR, 8'h00);
    chk("rst_srst", SOFT_RESET, 0);
    chk("rst_pwrdwn", PWRDWN, 0);
    chk("rst_ireq", IREQ_N, 1);
    chk("rst_ready", READY, 0);
    chk("rst_cfg", CONFIGURED, 0);
    RESET = 0;
    chk("ready_after_rst", READY, 0);
    tick(1);
    chk("ready_up", READY, 1);

    // COR = 0x41: configured, level-mode interrupts
    wr(10'h200, 8'h41);
    chk("cfg_level", CONFIGURED, 1);
    rd(10'h200, 3, 8'h00, 8'h41, "rd_cor41");
    INT_IN = 1; tick(4);
    chk("level_irq_low", IREQ_N, 0);
    INT_IN = 0; tick(4);
    chk("level_irq_high", IREQ_N, 1);

    // CIS byte read at A = 0x00A
    rd(10'h00A, 4, 8'h41, 8'h5A, "rd_cis");
    chk("cis_addr", CIS_ADDR, 8'h05);

    // Pulse mode: two INT_IN rises 3 cycles apart give one 11-cycle window
    wr(10'h200, 8'h01);
    chk("cfg_pulse", CONFIGURED, 1);
    lows = 0; falls = 0; prev_irq = IREQ_N;
    for (int i = 0; i < 30; i++) begin
      INT_IN = (i == 0 || i == 3);
      @(negedge CLK);
      if (IREQ_N === 1'b0) lows = lows + 1;
      if (IREQ_N === 1'b0 && prev_irq === 1'b1) falls = falls + 1;
      prev_irq = IREQ_N;
    end
    chk("pulse_low_cycles", lows, 11);
    chk("pulse_windows", falls, 1);

    // CCSR: PwrDwn write and Intr readback
    wr(10'h202, 8'h04);
    chk("pwrdwn_set", PWRDWN, 1);
    INT_IN = 1; tick(3);
    rd(10'h202, 3, 8'h5A, 8'h06, "rd_ccsr");
    rd(10'h204, 3, 8'h06, 8'h00, "rd_unused");
    INT_IN = 0; tick(3);

    // Soft reset: 0x80 then 0x01, exactly 16 cycles of SOFT_RESET
    srst_hi = 0;
    wr(10'h200, 8'h80);
    chk("srst_on", SOFT_RESET, 1);
    chk("srst_pwrdwn_clr", PWRDWN, 0);
    chk("srst_ready_low", READY, 0);
    chk("srst_cfg_low", CONFIGURED, 0);
    wr(10'h200, 8'h01);
    for (int i = 0; i < 40 && SOFT_RESET; i++) tick(1);
    chk("srst_off", SOFT_RESET, 0);
    chk("srst_width", srst_hi, 16);
    chk("srst_ready_lag", READY, 0);
    tick(1);
    chk("srst_ready_back", READY, 1);
    chk("srst_cfg_back", CONFIGURED, 1);
    rd(10'h200, 3, 8'h00, 8'h01, "rd_cor01");

    // RESET in the middle of a held write: no commit afterwards
    A = 10'h200; D_in = 8'h01; CE_N = 0; REGSEL_N = 0; WE_N = 0;
    tick(4);
    RESET = 1; tick(2);
    RESET = 0; tick(3);
    WE_N = 1; tick(5);
    CE_N = 1; REGSEL_N = 1; tick(2);
    chk("rstwr_cfg", CONFIGURED, 0);
    rd(10'h200, 3, 8'h00, 8'h00, "rstwr_cor");
    wr(10'h200, 8'h41);
    rd(10'h200, 3, 8'h00, 8'h41, "rearm_cor");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
